// File: rtl/bias_pkg.sv
// Shared types, width helpers and saturation limits for the bias buffer.
// Contents: state_t FSM encoding, counter/index width functions, default
// parameter values and the signed saturation limits for the default width.
package bias_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_t;

    localparam int DEF_NUM_WIDTH   = 16;
    localparam int DEF_DEPTH       = 64;
    localparam int DEF_SHIFT_WIDTH = 4;

    // Width of a count that must hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Width of an index 0..depth-1 (never narrower than one bit).
    function automatic int idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam logic [DEF_NUM_WIDTH-1:0] MAX_POS = {1'b0, {(DEF_NUM_WIDTH-1){1'b1}}};
    localparam logic [DEF_NUM_WIDTH-1:0] MAX_NEG = {1'b1, {(DEF_NUM_WIDTH-1){1'b0}}};

endpackage

// File: rtl/bias_format.sv
// Bias pre-formatter: arithmetic left shift of a signed raw bias, saturated to NUM_WIDTH.
// Latency: purely combinational. Backpressure: none, no handshake.
// Ports: i_data raw signed word, i_shift shift amount, o_data formatted signed word.
module bias_format #(
    parameter int NUM_WIDTH   = 16,
    parameter int SHIFT_WIDTH = 4
) (
    input  logic [NUM_WIDTH-1:0]   i_data,
    input  logic [SHIFT_WIDTH-1:0] i_shift,
    output logic [NUM_WIDTH-1:0]   o_data
);

    localparam int MAX_SH = (2 ** SHIFT_WIDTH) - 1;
    localparam int WIDE_W = NUM_WIDTH + MAX_SH;

    localparam logic [NUM_WIDTH-1:0] SAT_POS = {1'b0, {(NUM_WIDTH-1){1'b1}}};
    localparam logic [NUM_WIDTH-1:0] SAT_NEG = {1'b1, {(NUM_WIDTH-1){1'b0}}};

    logic signed [WIDE_W-1:0] w_ext;
    logic signed [WIDE_W-1:0] w_shifted;
    logic [MAX_SH:0]          w_upper;
    logic                     w_fits;

    // Wide enough that the shift never loses bits; overflow is judged afterwards.
    assign w_ext     = {{MAX_SH{i_data[NUM_WIDTH-1]}}, i_data};
    assign w_shifted = w_ext <<< i_shift;

    // Result fits when every bit above the narrow sign bit equals that sign bit.
    assign w_upper = w_shifted[WIDE_W-1:NUM_WIDTH-1];
    assign w_fits  = (w_upper == '0) || (w_upper == '1);

    always_comb begin
        o_data = w_shifted[NUM_WIDTH-1:0];
        if (!w_fits) begin
            o_data = w_shifted[WIDE_W-1] ? SAT_NEG : SAT_POS;
        end
    end

endmodule

// File: rtl/bias_buffer.sv
// Per-channel bias store: loads formatted biases over valid/ready, serves one per channel.
// Latency: bias/bias_index update 1 cycle after next/rewind; first bias valid on the last-word edge.
// Backpressure: bias_ready is registered, high only while loading; words taken on valid&&ready.
// Ports: clk/rst, cfg_count/cfg_shift/load_start config, bias_valid/bias_data/bias_ready
//        load stream, load_done status, next/rewind channel stepping, bias/bias_index output.
module bias_buffer
    import bias_pkg::*;
#(
    parameter int NUM_WIDTH   = DEF_NUM_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [cnt_w(DEPTH)-1:0]  cfg_count,
    input  logic [SHIFT_WIDTH-1:0]   cfg_shift,
    input  logic                     load_start,
    input  logic                     bias_valid,
    input  logic [NUM_WIDTH-1:0]     bias_data,
    output logic                     bias_ready,
    output logic                     load_done,
    input  logic                     next,
    input  logic                     rewind,
    output logic [NUM_WIDTH-1:0]     bias,
    output logic [idx_w(DEPTH)-1:0]  bias_index
);

    localparam int CNT_W = cnt_w(DEPTH);
    localparam int IDX_W = idx_w(DEPTH);

    state_t                 r_state;
    logic [CNT_W-1:0]       r_count;
    logic [SHIFT_WIDTH-1:0] r_shift;
    logic [IDX_W-1:0]       r_wr_ptr;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_ready;
    logic                   r_done;
    logic [NUM_WIDTH-1:0]   r_bias;
    logic [NUM_WIDTH-1:0]   r_mem [DEPTH];

    logic [NUM_WIDTH-1:0]   w_fmt;
    logic [CNT_W-1:0]       w_cnt_clamped;
    logic [IDX_W-1:0]       w_last_idx;
    logic [IDX_W-1:0]       w_next_idx;
    logic                   w_take;
    logic                   w_last_wr;

    bias_format #(
        .NUM_WIDTH   (NUM_WIDTH),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_format (
        .i_data  (bias_data),
        .i_shift (r_shift),
        .o_data  (w_fmt)
    );

    assign w_cnt_clamped = (cfg_count > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_count;
    // r_count is 1..DEPTH whenever it is used, so count-1 always fits the index width.
    assign w_last_idx    = IDX_W'(r_count - 1'b1);
    assign w_next_idx    = (r_idx == w_last_idx) ? '0 : r_idx + 1'b1;
    assign w_last_wr     = (r_wr_ptr == w_last_idx);
    // A restart on the same edge discards the word, so it is not taken.
    assign w_take        = r_ready && bias_valid && !load_start;

    // Storage is deliberately left unreset so it maps to distributed RAM.
    always_ff @(posedge clk) begin
        if (w_take) begin
            r_mem[r_wr_ptr] <= w_fmt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_count  <= '0;
            r_shift  <= '0;
            r_wr_ptr <= '0;
            r_idx    <= '0;
            r_ready  <= 1'b0;
            r_done   <= 1'b0;
            r_bias   <= '0;
        end else if (load_start) begin
            r_wr_ptr <= '0;
            r_idx    <= '0;
            r_done   <= 1'b0;
            r_bias   <= '0;
            if (cfg_count == '0) begin
                r_state <= IDLE;
                r_ready <= 1'b0;
            end else begin
                r_state <= LOAD;
                r_count <= w_cnt_clamped;
                r_shift <= cfg_shift;
                r_ready <= 1'b1;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_take) begin
                        if (w_last_wr) begin
                            r_state <= SERVE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                            r_idx   <= '0;
                            // Single-word layer: entry 0 is being written this very edge.
                            r_bias  <= (r_count == CNT_W'(1)) ? w_fmt : r_mem[0];
                        end else begin
                            r_wr_ptr <= r_wr_ptr + 1'b1;
                        end
                    end
                end
                SERVE: begin
                    if (rewind) begin
                        r_idx  <= '0;
                        r_bias <= r_mem[0];
                    end else if (next) begin
                        r_idx  <= w_next_idx;
                        r_bias <= r_mem[w_next_idx];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bias_ready = r_ready;
    assign load_done  = r_done;
    assign bias       = r_bias;
    assign bias_index = r_idx;

endmodule

// File: tb/tb_bias_buffer.sv
module tb_bias_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  cfg_count;
    logic [3:0]  cfg_shift;
    logic        load_start;
    logic        bias_valid;
    logic [15:0] bias_data;
    logic        bias_ready;
    logic        load_done;
    logic        next;
    logic        rewind;
    logic [15:0] bias;
    logic [5:0]  bias_index;

    int n_tests = 0;
    int n_fail  = 0;

    bias_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_count  (cfg_count),
        .cfg_shift  (cfg_shift),
        .load_start (load_start),
        .bias_valid (bias_valid),
        .bias_data  (bias_data),
        .bias_ready (bias_ready),
        .load_done  (load_done),
        .next       (next),
        .rewind     (rewind),
        .bias       (bias),
        .bias_index (bias_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] raw;
        logic [3:0]  shift;
        logic [15:0] exp;
    } fmt_vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_load(input logic [6:0] cnt, input logic [3:0] sh);
        cfg_count  = cnt;
        cfg_shift  = sh;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        cfg_count  = 7'd0;
        cfg_shift  = 4'd0;
    endtask

    task automatic step_next();
        next = 1'b1;
        tick();
        next = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        fmt_vec_t    vecs[10];
        logic [15:0] w1  [4];
        logic [15:0] raw4[8];
        logic [15:0] exp4[8];
        logic [15:0] w6  [3];
        int          k;
        int          cyc;
        int          ready_cycles;

        vecs[0] = '{16'h0100, 4'd4,  16'h1000};
        vecs[1] = '{16'h4000, 4'd2,  16'h7FFF};
        vecs[2] = '{16'hC000, 4'd2,  16'h8000};
        vecs[3] = '{16'hF000, 4'd2,  16'hC000};
        vecs[4] = '{16'h0005, 4'd0,  16'h0005};
        vecs[5] = '{16'hFFFF, 4'd15, 16'h8000};
        vecs[6] = '{16'h0001, 4'd15, 16'h7FFF};
        vecs[7] = '{16'h0003, 4'd14, 16'h7FFF};
        vecs[8] = '{16'hFFFE, 4'd14, 16'h8000};
        vecs[9] = '{16'h7FFF, 4'd0,  16'h7FFF};

        w1   = '{16'h0005, 16'hFFFD, 16'h0007, 16'h0000};
        raw4 = '{16'h0010, 16'hFFF0, 16'h0123, 16'h8000, 16'h4000, 16'h0001, 16'hFFFF, 16'h1234};
        exp4 = '{16'h0020, 16'hFFE0, 16'h0246, 16'h8000, 16'h7FFF, 16'h0002, 16'hFFFE, 16'h2468};
        w6   = '{16'h000B, 16'hFFEA, 16'h0021};

        rst = 1'b1; cfg_count = 7'd0; cfg_shift = 4'd0; load_start = 1'b0;
        bias_valid = 1'b0; bias_data = 16'd0; next = 1'b0; rewind = 1'b0;
        #12;
        check("rst_ready", bias_ready, 0);
        check("rst_done",  load_done, 0);
        check("rst_bias",  bias, 0);
        check("rst_idx",   bias_index, 0);
        rst = 1'b0;
        tick();

        // Load of four words with valid held high.
        start_load(7'd4, 4'd0);
        check("t1_bias_in_load", bias, 0);
        check("t1_done_in_load", load_done, 0);
        ready_cycles = 0;
        bias_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bias_data = w1[i];
            if (bias_ready) ready_cycles++;
            tick();
        end
        bias_valid = 1'b0;
        check("t1_ready_cycles", ready_cycles, 4);
        check("t1_ready_drop", bias_ready, 0);
        check("t1_done", load_done, 1);
        check("t1_bias0", bias, 16'h0005);
        check("t1_idx0", bias_index, 0);

        // Stepping with wrap, and hold when idle.
        for (int i = 0; i < 5; i++) begin
            step_next();
            check("t2_step_bias", bias, w1[(i + 1) % 4]);
            check("t2_step_idx", bias_index, (i + 1) % 4);
            tick();
            check("t2_hold_bias", bias, w1[(i + 1) % 4]);
        end

        // Formatting table, each as a single-word layer (forwarded entry 0).
        for (int i = 0; i < 10; i++) begin
            start_load(7'd1, vecs[i].shift);
            bias_valid = 1'b1;
            bias_data  = vecs[i].raw;
            tick();
            bias_valid = 1'b0;
            check("t3_fmt_done", load_done, 1);
            check("t3_fmt_bias", bias, vecs[i].exp);
        end
        step_next();
        check("t3_wrap_single_idx", bias_index, 0);
        check("t3_wrap_single_bias", bias, 16'h7FFF);

        // Load of eight with random valid and stray next/rewind during LOAD.
        start_load(7'd8, 4'd1);
        k = 0;
        cyc = 0;
        while (k < 8 && cyc < 400) begin
            bias_valid = 1'($urandom_range(0, 1));
            next       = 1'($urandom_range(0, 1));
            rewind     = 1'($urandom_range(0, 1));
            bias_data  = raw4[k];
            check("t4_bias_zero_in_load", bias, 0);
            check("t4_idx_zero_in_load", bias_index, 0);
            if (bias_valid && bias_ready) k++;
            tick();
            cyc++;
        end
        bias_valid = 1'b0; next = 1'b0; rewind = 1'b0;
        check("t4_words_taken", k, 8);
        check("t4_done", load_done, 1);
        check("t4_ready_drop", bias_ready, 0);
        check("t4_entry0", bias, exp4[0]);
        for (int i = 1; i < 8; i++) begin
            step_next();
            check("t4_entry", bias, exp4[i]);
        end

        // Rewind wins over next; load_start wins over next.
        step_next();
        step_next();
        step_next();
        check("t5_idx2", bias_index, 2);
        next = 1'b1; rewind = 1'b1;
        tick();
        next = 1'b0; rewind = 1'b0;
        check("t5_rewind_idx", bias_index, 0);
        check("t5_rewind_bias", bias, exp4[0]);
        next = 1'b1;
        start_load(7'd3, 4'd0);
        next = 1'b0;
        check("t5_ls_bias", bias, 0);
        check("t5_ls_done", load_done, 0);
        check("t5_ls_ready", bias_ready, 1);

        // Async reset mid-LOAD after two words.
        bias_valid = 1'b1;
        bias_data = 16'd100; tick();
        bias_data = 16'd200; tick();
        bias_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_async_ready", bias_ready, 0);
        check("t6_async_done", load_done, 0);
        #1 rst = 1'b0;
        tick();

        // Restart mid-LOAD, then a fresh three-word layer.
        start_load(7'd3, 4'd0);
        bias_valid = 1'b1; bias_data = 16'h0063; tick();
        bias_valid = 1'b0;
        start_load(7'd3, 4'd0);
        bias_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bias_data = w6[i];
            tick();
        end
        bias_valid = 1'b0;
        check("t6_reload_done", load_done, 1);
        check("t6_reload_e0", bias, w6[0]);
        for (int i = 1; i < 4; i++) begin
            step_next();
            check("t6_reload_step", bias, w6[i % 3]);
        end

        // Async reset while serving a non-zero bias.
        #2 rst = 1'b1;
        #1;
        check("t6_async_serve_bias", bias, 0);
        check("t6_async_serve_done", load_done, 0);
        #1 rst = 1'b0;
        tick();

        // cfg_count above DEPTH clamps to 64 entries.
        start_load(7'd100, 4'd0);
        bias_valid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            bias_data = 16'(i + 1);
            tick();
        end
        bias_valid = 1'b0;
        check("t6_clamp_done", load_done, 1);
        check("t6_clamp_e0", bias, 1);
        for (int i = 1; i < 64; i++) step_next();
        check("t6_clamp_last_idx", bias_index, 63);
        check("t6_clamp_last_bias", bias, 64);
        step_next();
        check("t6_clamp_wrap_idx", bias_index, 0);

        // cfg_count = 0 stays idle.
        start_load(7'd0, 4'd0);
        check("t6_zero_ready", bias_ready, 0);
        check("t6_zero_done", load_done, 0);
        check("t6_zero_bias", bias, 0);
        bias_valid = 1'b1; bias_data = 16'h1111;
        tick(); tick();
        bias_valid = 1'b0;
        check("t6_zero_still_idle", bias_ready, 0);
        step_next();
        check("t6_zero_next_ignored", bias_index, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
